snd_sample_fifo: RTL
====================

Name: snd_sample_fifo

Overview:
- Stereo PCM sample buffer that feeds audio_out_ds inside mega_ed.
- mega_ed register/MCU logic pushes L/R frames at arbitrary burst rates. The block pops one frame per snd_next_sample strobe and applies master volume plus a click-free fade on snd_on changes.
- It drives snd_l/snd_r and holds them stable between pops.

Parameters:
- DEPTH_LOG2, 9, FIFO depth = 2^DEPTH_LOG2 stereo frames.
- FADE_STEPS_LOG2, 8, fade ramp length = 2^FADE_STEPS_LOG2 pops.

Ports:
- clk  in  1  system clock (CLK, 50 MHz)
- rst  in  1  synchronous, active-low reset
- wr_en  in  1  one-clk push strobe for the frame on wr_l/wr_r
- wr_l  in  16  signed left sample
- wr_r  in  16  signed right sample
- fifo_clr  in  1  one-clk flush: pointers to 0, flags kept
- flag_clr  in  1  clears ovf/unf
- snd_on  in  1  audio enable; edges drive the fade
- vol  in  8  master volume; gain = (vol+1)/256, so 255 is exact unity
- snd_next_sample  in  1  one-clk pop request from audio_out_ds
- snd_l  out  16  signed left output
- snd_r  out  16  signed right output
- level  out  DEPTH_LOG2+1  stored frame count
- full  out  1  level == 2^DEPTH_LOG2
- empty  out  1  level == 0
- ovf  out  1  sticky: push dropped
- unf  out  1  sticky: pop while empty

Behaviour:
- Reset (rst==0 at clk edge):
  - wr/rd pointers, level, fade = 0; fade FSM = MUTE.
  - snd_l/snd_r = 0, ovf/unf = 0, empty = 1, full = 0.
  - Reset mid-burst discards all stored frames.
- Push:
  - Accepted if !full, or if full and a pop occurs in the same clk (level unchanged).
  - Otherwise the push is dropped and ovf is set.
- Pop (snd_next_sample==1):
  - If !empty: read the head and advance rd_ptr.
  - If empty: no pointer change, unf set, previous frame re-used (hold, no bypass of a same-cycle push).
- Pointers wrap modulo 2^DEPTH_LOG2. level is derived from the pointers with an extra wrap bit.
- fifo_clr takes priority over a push and a pop in the same clk. flag_clr is lower priority than a same-clk set event (the set wins).
- Pipeline, pop at clk N:
  - N+1: dual-port RAM registered read → frame register.
  - N+2: v = (s * (vol+1)) >>> 8, 25-bit product, arithmetic shift.
  - N+3: o = (v * fade) >>> FADE_STEPS_LOG2 → snd_l/snd_r registers.
  - Output latency is 3 clks. Outputs change only at N+3 of a pop; vol changes take effect at the next pop.
  - No saturation needed: |gain| ≤ 1 and fade ≤ 2^FADE_STEPS_LOG2.
- Fade FSM; fade range 0..2^FADE_STEPS_LOG2 (9 bits); steps happen only on pop strobes:
  - MUTE: fade = 0. snd_on=1 → RAMP_UP.
  - RAMP_UP: fade += 1 per pop. At max → PLAY. snd_on=0 → RAMP_DN (from the current fade).
  - PLAY: fade = max. snd_on=0 → RAMP_DN.
  - RAMP_DN: fade -= 1 per pop. At 0 → MUTE. snd_on=1 → RAMP_UP.
- In MUTE, pops still drain the FIFO (timing preserved); outputs are 0.

Decomposition:
- snd_pkg holds:
  - typedef struct packed {logic signed [15:0] l, r;} snd_frame_t
  - enum fade_st_t {MUTE, RAMP_UP, PLAY, RAMP_DN}
  - localparam FADE_MAX = 1 << FADE_STEPS_LOG2
- Sub-module snd_fifo_ram: simple dual-port, 32-bit wide, registered read, inferred block RAM.

Test Plan:
- Reset; snd_on=1, wait 256 pops (fade=256); vol=255; push (1000,-1000); pop → snd_l=1000, snd_r=-1000 exactly 3 clks after the strobe.
- vol=127, push (1000,-1000), pop → (500,-500); push (-1,0) → (-1,0), confirming arithmetic-shift rounding toward −inf.
- PLAY with vol=255 and constant frame 1000; drop snd_on, then 128 pops → snd_l=500; after 256 pops → 0 and FSM=MUTE.
- Push 513 frames with DEPTH_LOG2=9 → full=1, level=512, ovf=1; push+pop in the same clk while full → level stays 512, no new ovf.
- Empty FIFO, last output 700, pop → snd_l stays 700, unf=1; flag_clr → unf=0; push and pop in the same clk while empty → held value, level=1 afterwards.
- 3 frames stored, then rst=0 for one clk mid-pop → level=0, empty=1, snd_l/snd_r=0, FSM=MUTE.

Source files
------------

// File: rtl/snd_pkg.sv
// Shared types for the stereo sample FIFO: frame layout, fade FSM states and
// default fade ramp length.
package snd_pkg;

   localparam int DATA_W               = 16;
   localparam int FADE_STEPS_LOG2_DFLT = 8;
   localparam int FADE_MAX             = 1 << FADE_STEPS_LOG2_DFLT;

   typedef struct packed {
      logic signed [DATA_W-1:0] l;
      logic signed [DATA_W-1:0] r;
   } snd_frame_t;

   typedef enum logic [1:0] {
      MUTE    = 2'd0,
      RAMP_UP = 2'd1,
      PLAY    = 2'd2,
      RAMP_DN = 2'd3
   } fade_st_t;

endpackage

// File: rtl/snd_fifo_ram.sv
// Simple dual-port frame store with a registered, read-first output port so a
// same-address write in the same clock returns the old word.
module snd_fifo_ram
   import snd_pkg::*;
#(
   parameter int ADDR_W = 9
) (
   input  logic                           clk,
   input  logic                           we_i,
   input  logic [ADDR_W-1:0]              waddr_i,
   input  logic [$bits(snd_frame_t)-1:0]  wdata_i,
   input  logic                           re_i,
   input  logic [ADDR_W-1:0]              raddr_i,
   output logic [$bits(snd_frame_t)-1:0]  rdata_o
);

   localparam int WIDTH = $bits(snd_frame_t);

   logic [WIDTH-1:0] mem_q [2**ADDR_W];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/snd_sample_fifo.sv
// Stereo PCM frame FIFO feeding the audio DAC: pops one frame per strobe,
// applies master volume and a click-free fade, holds outputs between pops.
module snd_sample_fifo
   import snd_pkg::*;
#(
   parameter int DEPTH_LOG2      = 9,
   parameter int FADE_STEPS_LOG2 = FADE_STEPS_LOG2_DFLT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic signed [DATA_W-1:0] wr_l,
   input  logic signed [DATA_W-1:0] wr_r,
   input  logic                     fifo_clr,
   input  logic                     flag_clr,
   input  logic                     snd_on,
   input  logic [7:0]               vol,
   input  logic                     snd_next_sample,
   output logic signed [DATA_W-1:0] snd_l,
   output logic signed [DATA_W-1:0] snd_r,
   output logic [DEPTH_LOG2:0]      level,
   output logic                     full,
   output logic                     empty,
   output logic                     ovf,
   output logic                     unf
);

   localparam int                  FADE_W    = FADE_STEPS_LOG2 + 1;
   localparam logic [FADE_W-1:0]   FADE_TOP  = {1'b1, {FADE_STEPS_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam int                  VOL_PW    = DATA_W + 9;
   localparam int                  FADE_PW   = DATA_W + FADE_W + 1;

   function automatic logic signed [DATA_W-1:0] apply_vol(
      input logic signed [DATA_W-1:0] s,
      input logic [7:0]               v
   );
      logic signed [VOL_PW-1:0] gain;
      logic signed [VOL_PW-1:0] prod;
      gain = $signed(VOL_PW'({1'b0, v}) + VOL_PW'(1));
      prod = VOL_PW'(s) * gain;
      return DATA_W'(prod >>> 8);
   endfunction

   function automatic logic signed [DATA_W-1:0] apply_fade(
      input logic signed [DATA_W-1:0] s,
      input logic [FADE_W-1:0]        f
   );
      logic signed [FADE_PW-1:0] fs;
      logic signed [FADE_PW-1:0] prod;
      fs   = $signed({{(FADE_PW-FADE_W){1'b0}}, f});
      prod = FADE_PW'(s) * fs;
      return DATA_W'(prod >>> FADE_STEPS_LOG2);
   endfunction

   logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0] lvl;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic                full_w, empty_w;
   logic                pop_req, pop_do, push_do;

   fade_st_t            st_q, st_d;
   logic [FADE_W-1:0]   fade_q, fade_d;

   snd_frame_t          wr_frame;
   snd_frame_t          rd_frame;
   snd_frame_t          frm_p1;
   logic                vld_p1_q, vld_p2_q, frm_ok_q;
   logic [7:0]          vol_p1_q;
   logic signed [DATA_W-1:0] v_l_p2_q, v_r_p2_q;
   logic [FADE_W-1:0]   fade_p2_q;
   logic signed [DATA_W-1:0] snd_l_q, snd_r_q;

   assign lvl     = wr_ptr_q - rd_ptr_q;
   assign full_w  = (lvl == DEPTH_CNT);
   assign empty_w = (lvl == '0);
   assign pop_req = snd_next_sample && !fifo_clr;
   assign pop_do  = pop_req && !empty_w;
   assign push_do = wr_en && !fifo_clr && (!full_w || pop_do);

   // A set event in the same clock overrides flag_clr.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (flag_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (fifo_clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_do) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_do)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (wr_en && !push_do) ovf_d = 1'b1;
         if (pop_req && empty_w) unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q   <= MUTE;
         fade_q <= '0;
      end else begin
         st_q   <= st_d;
         fade_q <= fade_d;
      end
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         MUTE:    if (snd_on) st_d = RAMP_UP;
         RAMP_UP: begin
            if (!snd_on) st_d = RAMP_DN;
            else if (fade_q == FADE_TOP || (pop_req && fade_q == FADE_TOP - 1'b1)) st_d = PLAY;
         end
         PLAY:    if (!snd_on) st_d = RAMP_DN;
         RAMP_DN: begin
            if (snd_on) st_d = RAMP_UP;
            else if (fade_q == '0 || (pop_req && fade_q == FADE_W'(1))) st_d = MUTE;
         end
         default: st_d = MUTE;
      endcase
   end

   always_comb begin
      fade_d = fade_q;
      case (st_q)
         MUTE:    fade_d = '0;
         RAMP_UP: if (pop_req && snd_on && fade_q < FADE_TOP) fade_d = fade_q + 1'b1;
         PLAY:    fade_d = FADE_TOP;
         RAMP_DN: if (pop_req && !snd_on && fade_q != '0) fade_d = fade_q - 1'b1;
         default: fade_d = '0;
      endcase
   end

   assign wr_frame = '{l: wr_l, r: wr_r};

   snd_fifo_ram #(
      .ADDR_W (DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .we_i    (push_do),
      .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
      .wdata_i (wr_frame),
      .re_i    (pop_do),
      .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
      .rdata_o (rd_frame)
   );

   // Stage p1: frame register (RAM output) plus side-band captured at the pop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         frm_ok_q <= 1'b0;
      end else begin
         vld_p1_q <= pop_req;
         vld_p2_q <= vld_p1_q;
         if (pop_do) frm_ok_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (pop_req) vol_p1_q <= vol;
   end

   assign frm_p1 = frm_ok_q ? rd_frame : '0;

   // Stage p2: master volume.
   always_ff @(posedge clk) begin
      if (vld_p1_q) begin
         v_l_p2_q  <= apply_vol(frm_p1.l, vol_p1_q);
         v_r_p2_q  <= apply_vol(frm_p1.r, vol_p1_q);
         fade_p2_q <= fade_q;
      end
   end

   // Stage p3: fade gain into the held output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         snd_l_q <= '0;
         snd_r_q <= '0;
      end else if (vld_p2_q) begin
         snd_l_q <= apply_fade(v_l_p2_q, fade_p2_q);
         snd_r_q <= apply_fade(v_r_p2_q, fade_p2_q);
      end
   end

   assign snd_l = snd_l_q;
   assign snd_r = snd_r_q;
   assign level = lvl;
   assign full  = full_w;
   assign empty = empty_w;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule
